// File: rtl/pipe_hazard_if.sv
// Hazard-unit bundle: ID-stage operand/control info and
// the stall, flush and bypass controls returned to the datapath.
interface pipe_hazard_if #(
  parameter int RFIDX_WIDTH = 5,
  parameter int NSTAGE      = 3,
  parameter int NRD         = 2
);
  localparam int SELW = $clog2(NSTAGE);

  logic                       id_valid;
  logic [NRD*RFIDX_WIDTH-1:0] id_rs;
  logic [NRD-1:0]             id_rs_used;
  logic [RFIDX_WIDTH-1:0]     id_rd;
  logic                       id_reg_write;
  logic                       id_is_load;
  logic                       redirect;
  logic                       mem_busy;
  logic                       stall_f;
  logic                       stall_d;
  logic                       flush_d;
  logic                       flush_e;
  logic [NRD*SELW-1:0]        fwd_sel;
  logic [15:0]                stall_cnt;
  logic [15:0]                flush_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd,
    output id_reg_write, id_is_load, redirect, mem_busy,
    input  stall_f, stall_d, flush_d, flush_e,
    input  fwd_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd,
    input  id_reg_write, id_is_load, redirect, mem_busy,
    output stall_f, stall_d, flush_d, flush_e,
    output fwd_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard/forwarding controller, EX..WB tracking.
// Define HAZ_PERF_EN for saturating stall/flush event counters.
module pipe_hazard_unit #(
  parameter int RFIDX_WIDTH = 5,
  parameter int NSTAGE      = 3,
  parameter int LOAD_STAGE  = 2,
  parameter int NRD         = 2
) (
  input logic          clk,
  input logic          rst,
  pipe_hazard_if.slave bus
);
  localparam int RW   = RFIDX_WIDTH;
  localparam int SELW = $clog2(NSTAGE);

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
  } sb_ent_t;

  sb_ent_t           r_sb [NSTAGE];
  logic [NRD*RW-1:0] r_ex_rs;
  logic [NRD-1:0]    r_ex_used;

  sb_ent_t             w_ent;
  logic                w_load_use;
  logic                w_redir;
  logic                w_busy;
  logic                w_flush_e;
  logic [NRD*SELW-1:0] w_fwd;

  assign w_busy  = bus.mem_busy;
  assign w_redir = bus.redirect & ~rst;

  always_comb begin
    w_ent    = '0;
    w_ent.v  = bus.id_valid;
    w_ent.rd = bus.id_rd;
    w_ent.we = bus.id_reg_write & bus.id_valid
             & (bus.id_rd != '0);
    w_ent.ld = bus.id_is_load & bus.id_valid;
  end

  // Only the youngest writer counts: an older load
  // hidden behind a younger ALU write never stalls.
  always_comb begin
    logic          hit;
    logic [RW-1:0] s;
    hit        = 1'b0;
    s          = '0;
    w_load_use = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      s   = bus.id_rs[p*RW +: RW];
      hit = 1'b0;
      for (int j = 0; j < NSTAGE; j++) begin
        if (!hit && bus.id_rs_used[p] && s != '0
            && r_sb[j].v && r_sb[j].we
            && r_sb[j].rd == s) begin
          hit = 1'b1;
          if (r_sb[j].ld && (j + 1 < LOAD_STAGE))
            w_load_use = 1'b1;
        end
      end
    end
    w_load_use = w_load_use & bus.id_valid;
  end

  always_comb begin
    logic          hit;
    logic [RW-1:0] s;
    hit   = 1'b0;
    s     = '0;
    w_fwd = '0;
    for (int p = 0; p < NRD; p++) begin
      s   = r_ex_rs[p*RW +: RW];
      hit = 1'b0;
      for (int k = 1; k < NSTAGE; k++) begin
        if (!hit && r_ex_used[p] && s != '0
            && r_sb[k].v && r_sb[k].we
            && r_sb[k].rd == s) begin
          hit = 1'b1;
          w_fwd[p*SELW +: SELW] = SELW'(k);
        end
      end
    end
  end

  assign w_flush_e   = (w_load_use | w_redir) & ~w_busy;
  assign bus.stall_f = w_busy | (w_load_use & ~w_redir);
  assign bus.stall_d = w_busy | (w_load_use & ~w_redir);
  assign bus.flush_d = w_redir & ~w_busy;
  assign bus.flush_e = w_flush_e;
  assign bus.fwd_sel = w_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTAGE; i++)
        r_sb[i] <= '0;
      r_ex_rs   <= '0;
      r_ex_used <= '0;
    end else if (!w_busy) begin
      for (int i = NSTAGE - 1; i >= 1; i--)
        r_sb[i] <= r_sb[i-1];
      if (w_flush_e) begin
        r_sb[0]   <= '0;
        r_ex_rs   <= '0;
        r_ex_used <= '0;
      end else begin
        r_sb[0]   <= w_ent;
        r_ex_rs   <= bus.id_rs;
        r_ex_used <= bus.id_rs_used;
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!w_busy) begin
      if (w_load_use && !w_redir && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_redir && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed instruction streams for pipe_hazard_unit; expected
// controls are queued at drive time and checked mid-cycle.
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_hazard_if #(
    .RFIDX_WIDTH(5), .NSTAGE(3), .NRD(2)
  ) bus ();

  pipe_hazard_unit #(
    .RFIDX_WIDTH(5), .NSTAGE(3),
    .LOAD_STAGE(2), .NRD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        sf;
    logic        fd;
    logic        fe;
    logic [3:0]  fwd;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_sc  = 0;
  int m_fc  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string tag,
    input logic r, input logic busy, input logic rdr,
    input logic v, input logic [4:0] rs0,
    input logic [4:0] rs1, input logic [1:0] used,
    input logic [4:0] rd, input logic we, input logic ld,
    input logic sf, input logic fd, input logic fe,
    input logic [3:0] fwd);
    exp_t e;
    rst              = r;
    bus.mem_busy     = busy;
    bus.redirect     = rdr;
    bus.id_valid     = v;
    bus.id_rs        = {rs1, rs0};
    bus.id_rs_used   = used;
    bus.id_rd        = rd;
    bus.id_reg_write = we;
    bus.id_is_load   = ld;
    e.sf  = sf;
    e.fd  = fd;
    e.fe  = fe;
    e.fwd = fwd;
    e.sc  = (PERF && !r) ? 16'(m_sc) : 16'd0;
    e.fc  = (PERF && !r) ? 16'(m_fc) : 16'd0;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk({tag, ".stall_f"},   32'(bus.stall_f),   32'(e.sf));
    chk({tag, ".stall_d"},   32'(bus.stall_d),   32'(e.sf));
    chk({tag, ".flush_d"},   32'(bus.flush_d),   32'(e.fd));
    chk({tag, ".flush_e"},   32'(bus.flush_e),   32'(e.fe));
    chk({tag, ".fwd_sel"},   32'(bus.fwd_sel),   32'(e.fwd));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e.sc));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(e.fc));
    @(posedge clk);
    #1;
    if (r) begin
      m_sc = 0;
      m_fc = 0;
    end else if (!busy) begin
      if (fe && !rdr) m_sc++;
      if (rdr) m_fc++;
    end
  endtask

  task automatic nop(input string tag, input logic [3:0] fwd);
    step(tag, 0, 0, 0, 0, 5'd0, 5'd0, 2'b00,
         5'd0, 0, 0, 0, 0, 0, fwd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_busy     = 1'b0;
    bus.redirect     = 1'b0;
    bus.id_valid     = 1'b0;
    bus.id_rs        = '0;
    bus.id_rs_used   = '0;
    bus.id_rd        = '0;
    bus.id_reg_write = 1'b0;
    bus.id_is_load   = 1'b0;
    #2;
    // tag r bz rd | v rs0 rs1 used rd we ld | sf fd fe fwd
    step("rst", 1,0,0, 1,5'd7,5'd0,2'b01,5'd3,1,1, 0,0,0,4'h0);
    step("alu_a", 0,0,0, 1,5'd1,5'd2,2'b11,5'd5,1,0, 0,0,0,4'h0);
    step("alu_b", 0,0,0, 1,5'd5,5'd5,2'b11,5'd6,1,0, 0,0,0,4'h0);
    step("alu_c", 0,0,0, 1,5'd5,5'd0,2'b11,5'd11,1,0, 0,0,0,4'b0101);
    nop("alu_d", 4'b0010);
    nop("drn1", 4'h0);
    nop("drn2", 4'h0);
    step("lu_ld", 0,0,0, 1,5'd1,5'd0,2'b01,5'd7,1,1, 0,0,0,4'h0);
    step("lu_stall", 0,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 1,0,1,4'h0);
    step("lu_hold", 0,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 0,0,0,4'h0);
    nop("lu_fwd", 4'b0010);
    nop("drn3", 4'h0);
    nop("drn4", 4'h0);
    step("sh_ld", 0,0,0, 1,5'd1,5'd0,2'b01,5'd7,1,1, 0,0,0,4'h0);
    step("sh_addi", 0,0,0, 1,5'd0,5'd0,2'b01,5'd7,1,0, 0,0,0,4'h0);
    step("sh_add", 0,0,0, 1,5'd7,5'd7,2'b11,5'd9,1,0, 0,0,0,4'h0);
    nop("sh_fwd", 4'b0101);
    step("rd_ld", 0,0,0, 1,5'd1,5'd0,2'b01,5'd7,1,1, 0,0,0,4'h0);
    step("rd_both", 0,0,1, 1,5'd7,5'd0,2'b11,5'd8,1,0, 0,1,1,4'h0);
    nop("rd_after", 4'h0);
    nop("drn5", 4'h0);
    nop("drn6", 4'h0);
    step("mb_ld", 0,0,0, 1,5'd1,5'd0,2'b01,5'd7,1,1, 0,0,0,4'h0);
    for (int i = 0; i < 3; i++)
      step("mb_frz", 0,1,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 1,0,0,4'h0);
    step("mb_stall", 0,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 1,0,1,4'h0);
    step("mb_hold", 0,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 0,0,0,4'h0);
    nop("mb_fwd", 4'b0010);
    nop("drn7", 4'h0);
    nop("drn8", 4'h0);
    step("x0_ld", 0,0,0, 1,5'd1,5'd0,2'b01,5'd0,1,1, 0,0,0,4'h0);
    step("x0_rd", 0,0,0, 1,5'd0,5'd0,2'b11,5'd1,1,0, 0,0,0,4'h0);
    step("x0_lw7", 0,0,0, 1,5'd1,5'd0,2'b01,5'd7,1,1, 0,0,0,4'h0);
    step("rs_stall", 0,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 1,0,1,4'b0001);
    step("rs_rst", 1,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 0,0,0,4'h0);
    step("rs_post", 0,0,0, 1,5'd7,5'd0,2'b11,5'd8,1,0, 0,0,0,4'h0);
    nop("rs_tail", 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
